// File: rtl/io_pkg.sv
// Shared constants for the io_port block: port offsets from BASE, status
// register bit positions, the vctl interrupt-enable bit and the one-hot
// bus-state encodings.
package io_pkg;

    // Port offsets added to the BASE parameter of io_port
    localparam logic [7:0] OFS_BANK = 8'd0;
    localparam logic [7:0] OFS_VCTL = 8'd2;
    localparam logic [7:0] OFS_STAT = 8'd4;

    // Status register bit positions (other bits read as zero)
    localparam int STAT_PENDING = 0;
    localparam int STAT_VSYNC   = 1;

    // Interrupt-enable bit inside vctl
    localparam int VCTL_IE = 7;

    // One-hot bus states decoded from the strobes
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_WRITE = 4'b0010;
    localparam logic [3:0] ST_READ  = 4'b0100;
    localparam logic [3:0] ST_ACK   = 4'b1000;

endpackage

// File: rtl/io_port.sv
// io_port: small CPU I/O peripheral with a bank register, a video control
// register and a vsync-driven interrupt with vectored acknowledge.
// Writes commit once per bus cycle on the first pe sample of the strobe;
// read and vector data are registered every clock.
module io_port
    import io_pkg::*;
#(
    parameter logic [7:0] VECTOR = 8'hFF,
    parameter logic [7:0] BASE   = 8'h80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pe,
    input  logic        iorq,
    input  logic        m1,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic [7:0]  q,
    output logic        qe,
    output logic        irq,
    input  logic        vsync,
    output logic [7:0]  bank,
    output logic [7:0]  vctl
);

    logic [3:0] state;
    logic       is_write;
    logic       is_ack;
    logic       prev_write;
    logic       prev_ack;
    logic       wr_armed;
    logic       vsync_prev;
    logic       pending;
    logic       commit;
    logic       ack_first;
    logic       vsync_rise;
    logic       sel_bank;
    logic       sel_vctl;
    logic       sel_stat;
    logic [7:0] status;
    logic       unused_addr_hi;

    // Only the low address byte selects a port
    assign unused_addr_hi = ^a[15:8];
    assign sel_bank = (a[7:0] == BASE + OFS_BANK);
    assign sel_vctl = (a[7:0] == BASE + OFS_VCTL);
    assign sel_stat = (a[7:0] == BASE + OFS_STAT);

    // Decode the strobes into one bus state; ACK beats READ beats WRITE
    always_comb begin
        // NOTE: default first so every path assigns state and no latch is inferred.
        state = ST_IDLE;
        if (!iorq && !m1)
            state = ST_ACK;
        else if (!iorq && !rd)
            state = ST_READ;
        else if (!iorq && !wr)
            state = ST_WRITE;
    end

    assign is_write = (state == ST_WRITE);
    assign is_ack   = (state == ST_ACK);

    // A write commits only on its first sample, and only after the bus has
    // been seen idle since reset, so a strobe held across reset is ignored
    assign commit     = pe && is_write && !prev_write && wr_armed;
    assign ack_first  = pe && is_ack && !prev_ack;
    assign vsync_rise = vsync && !vsync_prev;

    // Previous-sample registers, advanced only on pe clocks
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every register see pre-edge values.
        if (reset) begin
            prev_write <= 1'b0;
            prev_ack   <= 1'b0;
            wr_armed   <= 1'b0;
        end else if (pe) begin
            prev_write <= is_write;
            prev_ack   <= is_ack;
            if (!is_write)
                wr_armed <= 1'b1;
        end
    end

    // vsync history tracks the pin through reset, so a level already high at
    // release is not mistaken for a rising edge
    always_ff @(posedge clock) begin
        // NOTE: deliberately not reset; during reset it still follows vsync.
        vsync_prev <= vsync;
    end

    // Bank and video control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            bank <= 8'h00;
            vctl <= 8'h00;
        end else if (commit) begin
            if (sel_bank)
                bank <= d;
            if (sel_vctl)
                vctl <= d;
        end
    end

    // Interrupt pending flag: a vsync edge wins over any clear on the same clock
    always_ff @(posedge clock) begin
        if (reset)
            pending <= 1'b0;
        else if (vsync_rise)
            pending <= 1'b1;
        else if (ack_first || (commit && sel_stat && d[STAT_PENDING]))
            pending <= 1'b0;
    end

    assign irq = ~(pending & vctl[VCTL_IE]);

    // Status register image
    always_comb begin
        status               = 8'h00;
        status[STAT_PENDING] = pending;
        status[STAT_VSYNC]   = vsync;
    end

    // Registered read / vector data, updated every clock
    always_ff @(posedge clock) begin
        if (reset) begin
            q  <= 8'h00;
            qe <= 1'b0;
        end else begin
            q  <= 8'h00;
            qe <= 1'b0;
            case (state)
                ST_ACK: begin
                    q  <= VECTOR;
                    qe <= 1'b1;
                end
                ST_READ: begin
                    if (sel_bank) begin
                        q  <= bank;
                        qe <= 1'b1;
                    end else if (sel_vctl) begin
                        q  <= vctl;
                        qe <= 1'b1;
                    end else if (sel_stat) begin
                        q  <= status;
                        qe <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: bus-level tasks drive CPU cycles, a small
// register model predicts results, and read/acknowledge data is checked
// through a scoreboard queue filled when the cycle is driven.
module tb_io_port;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pe    = 1'b0;
    logic        iorq  = 1'b1;
    logic        m1    = 1'b1;
    logic        rd    = 1'b1;
    logic        wr    = 1'b1;
    logic [15:0] a     = 16'h0000;
    logic [7:0]  d     = 8'h00;
    logic        vsync = 1'b0;
    logic [7:0]  q;
    logic        qe;
    logic        irq;
    logic [7:0]  bank;
    logic [7:0]  vctl;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the architectural state
    logic [7:0] m_bank    = 8'h00;
    logic [7:0] m_vctl    = 8'h00;
    logic       m_pending = 1'b0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    io_port #(.VECTOR(8'hFF), .BASE(8'h80)) dut (
        .clock (clock),
        .reset (reset),
        .pe    (pe),
        .iorq  (iorq),
        .m1    (m1),
        .rd    (rd),
        .wr    (wr),
        .a     (a),
        .d     (d),
        .q     (q),
        .qe    (qe),
        .irq   (irq),
        .vsync (vsync),
        .bank  (bank),
        .vctl  (vctl)
    );

    always #5 clock = ~clock;

    // pe high on every other rising edge; it changes 2ns after the edge
    initial forever begin
        @(posedge clock);
        #2 pe = ~pe;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    function automatic logic exp_irq();
        return ~(m_pending & m_vctl[7]);
    endfunction

    function automatic logic [8:0] exp_read(input logic [7:0] addr);
        case (addr)
            8'h80:   return {1'b1, m_bank};
            8'h82:   return {1'b1, m_vctl};
            8'h84:   return {1'b1, 6'b0, vsync, m_pending};
            default: return 9'h000;
        endcase
    endfunction

    // Wait for n pe-qualified rising edges, then return on the falling edge
    task automatic wait_samples(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clock);
            if (pe)
                k++;
        end
        @(negedge clock);
    endtask

    // Return on a falling edge whose following rising edge samples the bus
    task automatic align_pe();
        @(negedge clock);
        while (!pe)
            @(negedge clock);
    endtask

    task automatic sb_compare();
        sb_entry_t e;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, {qe, q}, e.exp);
        end
    endtask

    // OUT cycle held for `samples` pe samples; data switches to late_d after
    // the first sample so a second commit would be visible
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                            input int samples, input logic [7:0] late_d);
        int n = 0;
        align_pe();
        a = {8'h00, addr}; d = data; iorq = 1'b0; wr = 1'b0;
        while (n < samples) begin
            @(posedge clock);
            if (pe)
                n++;
            @(negedge clock);
            if (n >= 1)
                d = late_d;
        end
        iorq = 1'b1; wr = 1'b1;
        if (addr == 8'h80) m_bank = data;
        if (addr == 8'h82) m_vctl = data;
        if (addr == 8'h84 && data[0]) m_pending = 1'b0;
        wait_samples(1);
    endtask

    task automatic io_read(input logic [7:0] addr, input string tag);
        sb_entry_t e;
        @(negedge clock);
        a = {8'h00, addr}; iorq = 1'b0; rd = 1'b0;
        e.tag = tag;
        e.exp = exp_read(addr);
        sb.push_back(e);
        @(negedge clock);
        sb_compare();
        iorq = 1'b1; rd = 1'b1;
        @(negedge clock);
    endtask

    task automatic int_ack();
        sb_entry_t e;
        align_pe();
        iorq = 1'b0; m1 = 1'b0;
        e.tag = "ack_vector";
        e.exp = {1'b1, 8'hFF};
        sb.push_back(e);
        @(negedge clock);
        m_pending = 1'b0;
        sb_compare();
        check("ack_irq", irq, exp_irq());
        iorq = 1'b1; m1 = 1'b1;
        wait_samples(1);
    endtask

    task automatic vsync_pulse();
        @(negedge clock);
        vsync = 1'b1;
        @(negedge clock);
        vsync = 1'b0;
        m_pending = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_bank", bank, 8'h00);
        check("rst_vctl", vctl, 8'h00);
        check("rst_q", q, 8'h00);
        check("rst_qe", qe, 1'b0);
        check("rst_irq", irq, 1'b1);
        wait_samples(1);

        // Write committed exactly once; non-decoded port ignored
        io_write(8'h80, 8'h5A, 3, 8'hA5);
        check("wr_bank_once", bank, m_bank);
        io_write(8'h81, 8'h11, 3, 8'h11);
        check("wr_81_bank", bank, m_bank);
        check("wr_81_vctl", vctl, m_vctl);

        // Reads
        io_write(8'h82, 8'h80, 2, 8'h80);
        check("vctl_80", vctl, m_vctl);
        check("irq_idle", irq, exp_irq());
        io_read(8'h82, "rd_vctl");
        io_read(8'h90, "rd_90_none");
        io_read(8'h80, "rd_bank");

        // Interrupt and acknowledge
        vsync_pulse();
        check("irq_set", irq, exp_irq());
        int_ack();
        io_read(8'h84, "rd_stat_after_ack");

        // Masking and write-to-clear
        io_write(8'h82, 8'h00, 1, 8'h00);
        vsync_pulse();
        check("irq_masked", irq, exp_irq());
        io_read(8'h84, "rd_stat_masked");
        io_write(8'h82, 8'h80, 1, 8'h80);
        check("irq_unmasked", irq, exp_irq());
        io_write(8'h84, 8'hFE, 1, 8'hFE);
        check("clr_bit0_zero", irq, exp_irq());
        io_write(8'h84, 8'h01, 1, 8'h01);
        check("clr_bit0_one", irq, exp_irq());

        // vsync edge on the same clock as a clearing write: set wins
        align_pe();
        a = 16'h0084; d = 8'h01; iorq = 1'b0; wr = 1'b0; vsync = 1'b1;
        @(negedge clock);
        vsync = 1'b0;
        m_pending = 1'b1;
        check("simul_irq", irq, exp_irq());
        iorq = 1'b1; wr = 1'b1;
        wait_samples(1);
        io_read(8'h84, "rd_stat_simul");
        io_write(8'h84, 8'h01, 1, 8'h01);

        // Reset asserted mid-write, released with wr still low and vsync high
        align_pe();
        a = 16'h0080; d = 8'h33; iorq = 1'b0; wr = 1'b0; reset = 1'b1; vsync = 1'b1;
        repeat (2) @(negedge clock);
        m_bank = 8'h00; m_vctl = 8'h00; m_pending = 1'b0;
        check("mid_rst_bank", bank, m_bank);
        check("mid_rst_vctl", vctl, m_vctl);
        check("mid_rst_irq", irq, exp_irq());
        reset = 1'b0; d = 8'h77;
        wait_samples(4);
        check("no_commit_after_rst", bank, 8'h00);
        iorq = 1'b1; wr = 1'b1;
        wait_samples(1);
        io_read(8'h84, "rd_stat_vsync_high");
        vsync = 1'b0;
        io_write(8'h80, 8'h77, 2, 8'h77);
        check("wr_after_rst", bank, m_bank);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
